dmem_port_arbiter: RTL

Shares the single data-memory port between the MEM stage and an auxiliary requester (debug/DMA), and sequences each access over the memory's fixed read latency. Sits between the MEM stage and data memory. Stalls the pipeline while a MEM-stage access is in flight or waiting, and returns registered read data with a one-cycle done pulse.

---
 rtl/dmem_port_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the MEM stage and an aux requester.
// Latency: grant in T, mem_en T+1..T+LATENCY, done/rvalid pulse in T+LATENCY+1.
// Backpressure: pipe_stall while a pipe access waits or is in flight; aux_ready on grant.
// Optional aux starvation guard: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter #(
    parameter int LATENCY      = 1,
    parameter int AUX_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_req,
    input  logic        pipe_we,
    input  logic [2:0]  pipe_type,
    input  logic [31:0] pipe_addr,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    output logic        pipe_done,
    output logic [31:0] pipe_rdata,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic        aux_we,
    input  logic [2:0]  aux_type,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    output logic        aux_rvalid,
    output logic [31:0] aux_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [2:0]  mem_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in
);

    if (LATENCY < 1 || LATENCY > 15 || AUX_MAX_WAIT < 1 || AUX_MAX_WAIT > 255) begin : g_bad_param
        $error("dmem_port_arbiter: LATENCY must be 1..15 and AUX_MAX_WAIT 1..255");
    end

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_PIPE = 2'd1,
        BUSY_AUX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        pipe_cand;
    logic        aux_win;
    logic        grant_pipe;
    logic        grant_aux;
    logic        last;
    logic        cmd_we;
    logic [2:0]  cmd_type;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    // The instruction leaving in its done cycle must not be granted again.
    assign pipe_cand  = pipe_req & ~pipe_done;
    assign pipe_stall = pipe_cand;
    assign aux_ready  = grant_aux;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    assign aux_win = aux_valid & (starve_cnt >= 8'(AUX_MAX_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 8'd0;
        end else if (grant_aux) begin
            starve_cnt <= 8'd0;
        end else if (aux_valid && starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    assign aux_win = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        grant_pipe = 1'b0;
        grant_aux  = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (pipe_cand && !aux_win) begin
                    grant_pipe = 1'b1;
                    state_nxt  = BUSY_PIPE;
                end else if (aux_valid) begin
                    grant_aux  = 1'b1;
                    state_nxt  = BUSY_AUX;
                end
            end
            BUSY_PIPE, BUSY_AUX: begin
                if (cnt == 4'd0) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_we    = grant_aux ? aux_we    : pipe_we;
        cmd_type  = grant_aux ? aux_type  : pipe_type;
        cmd_addr  = grant_aux ? aux_addr  : pipe_addr;
        cmd_wdata = grant_aux ? aux_wdata : pipe_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            pipe_done    <= 1'b0;
            aux_rvalid   <= 1'b0;
            pipe_rdata   <= 32'd0;
            aux_rdata    <= 32'd0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_type     <= 3'd0;
            mem_addr     <= 32'd0;
            mem_data_out <= 32'd0;
        end else begin
            state      <= state_nxt;
            pipe_done  <= last && (state == BUSY_PIPE);
            aux_rvalid <= last && (state == BUSY_AUX);

            if (grant_pipe || grant_aux) begin
                cnt <= CNT_INIT;
            end else if (state != IDLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (grant_pipe || grant_aux) begin
                mem_en       <= 1'b1;
                mem_we       <= cmd_we;
                mem_type     <= cmd_type;
                mem_addr     <= cmd_addr;
                mem_data_out <= cmd_wdata;
            end else if (last) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end

            // Stores leave the read-data registers untouched.
            if (last && !mem_we) begin
                if (state == BUSY_PIPE) begin
                    pipe_rdata <= mem_data_in;
                end else begin
                    aux_rdata <= mem_data_in;
                end
            end
        end
    end

endmodule
